// File: rtl/shift_add_multiplier_4_bit_if.sv
// shift_add_multiplier_4_bit_if: start/busy/done handshake bundle for the 4x4 shift-add multiplier
//   master drives start, A, B and observes busy, done, Product
//   slave  (the multiplier) observes start, A, B and drives busy, done, Product
interface shift_add_multiplier_4_bit_if;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       busy;
  logic       done;
  logic [7:0] Product;
  modport master (output start, A, B, input busy, done, Product);
  modport slave  (input start, A, B, output busy, done, Product);
endinterface

// File: rtl/shift_add_multiplier_4_bit.sv
// shift_add_multiplier_4_bit: sequential 4x4 unsigned shift-and-add multiplier built on a 4-bit ripple-carry adder
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave handshake (start, A, B in; busy, done, Product out)
module ripple_carry_adder_4_bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [3:0] Sum,
  output logic       C4
);
  logic [4:0] c;
  assign c[0] = 1'b0;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign Sum[i]  = A[i] ^ B[i] ^ c[i];
    assign c[i+1]  = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end
  assign C4 = c[4];
endmodule

module shift_add_multiplier_4_bit #(
  parameter int WIDTH = 4
) (
  input logic                        clk,
  input logic                        rst_n,
  shift_add_multiplier_4_bit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state_q;
  logic [WIDTH-1:0]   mcand_q, acc_q, mq_q;
  logic [1:0]         cnt_q;
  logic               busy_q, done_q;
  logic [2*WIDTH-1:0] product_q;
  logic [3:0]         sum;
  logic               c4;
  logic [7:0]         shift_d;
  ripple_carry_adder_4_bit u_rca (
    .A  (acc_q),
    .B  (mq_q[0] ? mcand_q : 4'h0),
    .Sum(sum),
    .C4 (c4)
  );
  // the carry becomes the new acc MSB; the bit shifted out of mq is the finished product bit
  assign shift_d = {c4, sum, mq_q[3:1]};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else if (state_q == IDLE) begin
      if (bus.start) begin
        mcand_q <= bus.A;
        mq_q    <= bus.B;
        acc_q   <= '0;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
        state_q <= RUN;
      end
    end else if (state_q == RUN) begin
      {acc_q, mq_q} <= shift_d;
      // counter holds at 3 on the final iteration; only the IDLE reload returns it to 0
      cnt_q <= (cnt_q == 2'd3) ? cnt_q : cnt_q + 2'd1;
      if (cnt_q == 2'd3) begin
        product_q <= shift_d;
        busy_q    <= 1'b0;
        done_q    <= 1'b1;
        state_q   <= DONE;
      end
    end else begin
      done_q  <= 1'b0;
      state_q <= IDLE;
    end
  end
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.Product = product_q;
endmodule
